// File: rtl/apb_req_bridge.sv
// apb_req_bridge: host valid/ready request -> two-phase sel/enable bus master.
// One transfer in flight; the response is held until the host accepts it.
// Optional build macro: APB_REQ_BRIDGE_TIMEOUT_EN enables an ACCESS-phase
// timeout that aborts a stalled transfer and returns rsp_err=1.
module apb_req_bridge #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  // host request channel
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  // host response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // slave bus
  output logic                  sel,
  output logic                  enable,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // A zero timeout would abort before the slave ever sees the strobe.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout_cfg
    $error("apb_req_bridge: TIMEOUT_CYCLES must be >= 1");
  end

`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  state_t                r_state;
  logic                  r_req_ready;
  logic                  r_sel;
  logic                  r_enable;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
  logic                  r_rsp_err;
  logic [CNT_W-1:0]      r_to_cnt;
`endif

  // Transfer sequencer: all bus and response outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_sel       <= 1'b0;
      r_enable    <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
      r_rsp_err   <= 1'b0;
      r_to_cnt    <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Bus address/data/direction change only here, at acceptance.
          if (req_valid) begin
            r_wr        <= req_wr;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_sel       <= 1'b1;
            r_enable    <= 1'b0;
            r_req_ready <= 1'b0;
            r_state     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          r_enable <= 1'b1;
          r_state  <= ST_ACCESS;
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
        end

        ST_ACCESS: begin
          // Slave completion wins over a timeout on the same edge.
          if (ready) begin
            r_rsp_rdata <= r_wr ? '0 : rdata;
            r_sel       <= 1'b0;
            r_enable    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
          end
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
          else if (r_to_cnt == CNT_LAST) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_sel       <= 1'b0;
            r_enable    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_to_cnt <= r_to_cnt + CNT_W'(1);
          end
`endif
        end

        ST_RESP: begin
          // Response stays put until the host takes it.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign sel       = r_sel;
  assign enable    = r_enable;
  assign wr        = r_wr;
  assign addr      = r_addr;
  assign wdata     = r_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
  assign rsp_err   = r_rsp_err;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_req_bridge.sv
// Bench for apb_req_bridge: behavioural slave memory, reference memory model,
// directed protocol steps followed by randomized transfers.
module tb_apb_req_bridge;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int          TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          sel;
  logic          enable;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready;
  logic [DW-1:0] rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] slave_mem [256];
  logic [DW-1:0] model_mem [256];
  int            slave_wait = 0;
  int            acc_cnt = 0;

  apb_req_bridge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .sel(sel), .enable(enable), .wr(wr), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata)
  );

  always #5 clk = ~clk;

  // Slave: ready after slave_wait ACCESS cycles; noise on ready/rdata otherwise.
  always @(negedge clk) begin
    if (sel && enable) begin
      if (acc_cnt >= slave_wait) begin
        ready = 1'b1;
        rdata = slave_mem[addr];
      end else begin
        ready = 1'b0;
        rdata = 8'($urandom);
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      ready   = 1'($urandom);
      rdata   = 8'($urandom);
    end
  end

  // Slave write port commits on the completing edge.
  always @(posedge clk) begin
    if (!reset && sel && enable && ready && wr) slave_mem[addr] = wdata;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the bridge will accept on the next edge.
  task automatic wait_ready(output int n);
    n = 0;
    while (!req_ready && n < 64) begin
      tick();
      n++;
    end
    chk("accept_bound", 32'(n < 64), 32'd1);
  endtask

  // One full transfer with protocol checks against the reference model.
  task automatic do_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input int wn, input int rd, input bit exp_imm,
                        input bit pend, input logic pw, input logic [7:0] pa,
                        input logic [7:0] pd);
    logic [7:0] exp_rd;
    int n;
    int en_cnt;
    slave_wait = wn;
    req_valid  = 1'b1;
    req_wr     = w;
    req_addr   = a;
    req_wdata  = d;
    rsp_ready  = (rd == 0);
    wait_ready(n);
    if (exp_imm) chk("turnaround_accept", n, 0);
    exp_rd = w ? 8'h00 : model_mem[a];
    tick();  // acceptance edge N
    req_valid = 1'b0;
    req_wr    = 1'($urandom);
    req_addr  = 8'($urandom);
    req_wdata = 8'($urandom);
    chk("setup_sel", sel, 1);
    chk("setup_enable", enable, 0);
    chk("setup_req_ready", req_ready, 0);
    chk("setup_addr", addr, a);
    chk("setup_wdata", wdata, d);
    chk("setup_wr", wr, w);
    tick();  // N+1
    chk("access_sel", sel, 1);
    chk("access_enable", enable, 1);
    en_cnt = 1;
    n = 0;
    while (enable && n < 64) begin
      tick();
      n++;
      if (enable) begin
        en_cnt++;
        chk("wait_addr", addr, a);
        chk("wait_wdata", wdata, d);
        chk("wait_wr", wr, w);
        chk("wait_rsp_valid", rsp_valid, 0);
      end
    end
    chk("enable_cycles", en_cnt, wn + 1);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_sel_low", sel, 0);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", rsp_err, 0);
    if (w) model_mem[a] = d;
    if (pend) begin
      req_valid = 1'b1;
      req_wr    = pw;
      req_addr  = pa;
      req_wdata = pd;
    end
    for (int i = 0; i < rd; i++) begin
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_sel", sel, 0);
      chk("hold_rdata", rsp_rdata, exp_rd);
      tick();
    end
    chk("hold_end_rsp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    chk("consumed_rsp_valid", rsp_valid, 0);
    chk("idle_req_ready", req_ready, 1);
  endtask

  initial begin
    int n;
    int en_cnt;
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = 8'h00;
      model_mem[i] = 8'h00;
    end
    reset     = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_req_ready", req_ready, 1);
    chk("rst_sel", sel, 0);
    chk("rst_enable", enable, 0);
    chk("rst_wr", wr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    reset = 1'b0;
    tick();

    // Zero-wait write, read-back, turnaround, unwritten location
    do_txn(1'b1, 8'h01, 8'hAA, 0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    do_txn(1'b0, 8'h01, 8'h00, 0, 0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    do_txn(1'b0, 8'h02, 8'h00, 0, 0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Three wait states
    do_txn(1'b1, 8'h10, 8'h5A, 3, 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    do_txn(1'b0, 8'h10, 8'h00, 3, 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Response backpressure with a second request pending
    do_txn(1'b1, 8'h05, 8'h3C, 0, 5, 1'b0, 1'b1, 1'b0, 8'h05, 8'h00);
    do_txn(1'b0, 8'h05, 8'h00, 0, 0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset during ACCESS drops the write without a response
    slave_wait = 1000;
    req_valid  = 1'b1;
    req_wr     = 1'b1;
    req_addr   = 8'h20;
    req_wdata  = 8'h77;
    wait_ready(n);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("pre_reset_enable", enable, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_sel", sel, 0);
    chk("midrst_enable", enable, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst_no_rsp", rsp_valid, 0);
    end
    slave_wait = 0;
    do_txn(1'b0, 8'h20, 8'h00, 0, 0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Leave a non-zero rsp_rdata behind, then stall the slave forever
    do_txn(1'b0, 8'h01, 8'h00, 0, 0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    slave_wait = 1000;
    rsp_ready  = 1'b0;
    req_valid  = 1'b1;
    req_wr     = 1'b0;
    req_addr   = 8'h01;
    req_wdata  = 8'h00;
    wait_ready(n);
    tick();
    req_valid = 1'b0;
    tick();
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
    en_cnt = 1;
    n = 0;
    while (enable && n < 64) begin
      tick();
      n++;
      if (enable) en_cnt++;
    end
    chk("timeout_enable_cycles", en_cnt, TO);
    chk("timeout_rsp_valid", rsp_valid, 1);
    chk("timeout_rsp_err", rsp_err, 1);
    chk("timeout_rsp_rdata", rsp_rdata, 0);
    chk("timeout_sel", sel, 0);
    tick();
    chk("timeout_err_held", rsp_err, 1);
    rsp_ready = 1'b1;
    tick();
    chk("timeout_consumed", rsp_valid, 0);
    chk("timeout_err_cleared", rsp_err, 0);
`else
    repeat (100) tick();
    chk("stall_enable", enable, 1);
    chk("stall_sel", sel, 1);
    chk("stall_rsp_valid", rsp_valid, 0);
    chk("stall_rsp_err", rsp_err, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("stall_recover_req_ready", req_ready, 1);
`endif
    slave_wait = 0;

    // Randomized traffic against the reference memory
    for (int t = 0; t < 40; t++) begin
      logic       w;
      logic [7:0] a;
      logic [7:0] d;
      w = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 7));
      d = 8'($urandom);
      do_txn(w, a, d, $urandom_range(0, 3), $urandom_range(0, 2),
             1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_req_bridge.md
Name: apb_req_bridge

Overview:
- Upstream master for the register bank: converts a host valid/ready request into a two-phase sel/enable bus transfer that the mem_block slave consumes.
- Waits on the slave's ready and captures rdata.
- Returns a held response (read data, error flag) to the host.
- One transfer in flight at a time. All bus outputs are registered.

Parameters:
- DATA_WIDTH, 8, width of wdata/rdata and host data buses.
- ADDR_WIDTH, 8, width of addr and req_addr.
- TIMEOUT_CYCLES, 16, ACCESS-phase cycles with ready low before abort (used only when the timeout feature is compiled in; must be ≥1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  host request present.
- req_ready  output  1  bridge can accept a request.
- req_wr  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  target address.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  response held for host.
- rsp_ready  input  1  host consumes response.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  output  1  transfer aborted by timeout.
- sel  output  1  slave select.
- enable  output  1  access-phase strobe.
- wr  output  1  bus direction.
- addr  output  ADDR_WIDTH  bus address.
- wdata  output  DATA_WIDTH  bus write data.
- ready  input  1  slave completes access.
- rdata  input  DATA_WIDTH  slave read data.

Behaviour:
- Reset values: state IDLE; req_ready=1; sel, enable, wr, rsp_valid, rsp_err = 0; addr, wdata, rsp_rdata = 0.
- Reset applies at the clock edge where reset=1, including mid-transfer. Any in-flight transfer is dropped with no response, and sel/enable are low after that edge.
- FSM has four states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, latch req_wr, req_addr and req_wdata into wr, addr and wdata, then go to SETUP. Set sel=1, enable=0.
- SETUP:
  - Lasts exactly 1 cycle, then ACCESS. Set enable=1.
- ACCESS:
  - sel=1, enable=1; addr, wr and wdata held stable.
  - On an edge with ready=1: capture rdata into rsp_rdata if wr=0, else set rsp_rdata=0. Set rsp_err=0, sel=0, enable=0, rsp_valid=1, then go to RESP.
  - With ready=0, stay in ACCESS. Wait states are unbounded unless the timeout feature is compiled in.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held.
  - On an edge with rsp_ready=1: rsp_valid=0, go to IDLE.
- req_ready=1 only in IDLE. A request arriving in any other state waits; it is never dropped or overwritten.
- Minimum turnaround, zero wait states: request accepted at edge N; sel high after N; enable high after N+1; ready sampled at N+2; rsp_valid high after N+2. With rsp_ready already high, back in IDLE after N+3, so the next acceptance is at N+4 at the earliest.
- addr, wdata and wr keep their last value outside a transfer; they change only at acceptance.
- ready and rdata are ignored outside ACCESS.

Optional Feature:
- Macro: APB_REQ_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter, sized to hold TIMEOUT_CYCLES, clears on entering ACCESS and increments on each ACCESS edge with ready=0.
  - On the edge where ready=0 and the count equals TIMEOUT_CYCLES-1: sel=0, enable=0, rsp_err=1, rsp_rdata=0, go to RESP.
  - ready=1 on that same edge takes priority, giving normal completion.
  - rsp_err stays 1 until the response is consumed.
- Undefined: no counter; rsp_err is tied to 0; ACCESS waits indefinitely.

Test Plan:
- Write, zero wait, bench slave ready=1 in ACCESS: req wr=1, addr=0x01, wdata=0xAA accepted at edge N → sel high after N, enable high after N+1, addr=0x01 and wdata=0xAA stable; rsp_valid high after N+2 with rsp_err=0 and rsp_rdata=0x00.
- Write then read through a mem_block instance (DATA_WIDTH 8, DEPTH 32, RESET_VAL 0x00): write 0xAA to addr 1, then read addr 1 → rsp_rdata=0xAA. A read of addr 2 → 0x00.
- Wait states: slave holds ready=0 for 3 ACCESS cycles → enable high for 4 cycles; addr, wdata and wr unchanged throughout; single rsp_valid afterwards.
- Response backpressure: rsp_ready=0 for 5 cycles while a second req_valid is pending → rsp_valid held, req_ready=0, sel=0. Second request accepted on the edge after rsp_ready rises.
- Reset mid-ACCESS: reset=1 for one cycle during ACCESS → after that edge sel=0, enable=0, rsp_valid=0, req_ready=1; no response emitted for the dropped request.
- APB_REQ_BRIDGE_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, ready never asserted → enable high for exactly 16 cycles; then rsp_valid=1, rsp_err=1, rsp_rdata=0x00. Without the macro: still in ACCESS after 100 cycles and rsp_err=0.
